// File: rtl/btn_cond_pkg.sv
// ============================================================================
//  Module  : btn_cond_pkg
//  Brief   : Channel state encoding, default timing and counter sizing for btn_conditioner.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_cond_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM_UP = 2'd1;
  localparam logic [1:0] S_HELD   = 2'd2;
  localparam logic [1:0] S_ARM_DN = 2'd3;

  localparam int DEF_DEBOUNCE_CYC = 500;
  localparam int DEF_REPEAT_DELAY = 2000000;
  localparam int DEF_REPEAT_RATE  = 500000;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_chan.sv
// ============================================================================
//  Module  : btn_chan
//  Brief   : One button: 2-FF synchroniser, debounce FSM and counter; optional
//            auto-repeat when AUTOREPEAT_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_chan
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ZERO     = '0;

  logic             meta_q, sync_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] C_DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_RATE_LAST = CNT_W'(REPEAT_RATE - 1);
  // Set after the first auto-repeat pulse; selects the shorter reload period.
  logic rep_q, rep_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    if (ena_i) begin
      case (state_q)
        S_IDLE: begin
          if (sync_q) begin
            state_d = S_ARM_UP;
            cnt_d   = C_ONE;
          end
        end
        S_ARM_UP: begin
          if (!sync_q) begin
            state_d = S_IDLE;
            cnt_d   = C_ZERO;
          end else if (cnt_q == C_DEB_LAST) begin
            state_d = S_HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
        S_HELD: begin
          if (!sync_q) begin
            state_d = S_ARM_DN;
            cnt_d   = C_ONE;
`ifdef AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
`ifdef AUTOREPEAT_EN
            if (cnt_q == (rep_q ? C_RATE_LAST : C_DLY_LAST)) begin
              press_d = 1'b1;
              cnt_d   = C_ZERO;
              rep_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
`else
            cnt_d = cnt_q;
`endif
          end
        end
        S_ARM_DN: begin
          if (sync_q) begin
            state_d = S_HELD;
            cnt_d   = C_ZERO;
          end else if (cnt_q == C_DEB_LAST) begin
            state_d   = S_IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = C_ZERO;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = C_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= C_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_q     <= 1'b0;
`endif
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
//  Module  : btn_conditioner
//  Brief   : N_BTN independent synchronise/debounce/edge-detect channels.
//            Optional auto-repeat enabled by defining AUTOREPEAT_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ena_i    (ena),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
//  Module  : tb_btn_conditioner
//  Brief   : Directed bench for btn_conditioner (DEBOUNCE_CYC=16, REPEAT_DELAY=64,
//            REPEAT_RATE=16); expectations follow AUTOREPEAT_EN when defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  int tests = 0;
  int fails = 0;
  int ec    = 0;
  int p_edges[$];
  int r_edges[$];
  bit lvl_seen;
  bit other_evt;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN       (4),
    .DEBOUNCE_CYC(16),
    .REPEAT_DELAY(64),
    .REPEAT_RATE (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic clear_obs();
    ec = 0;
    p_edges.delete();
    r_edges.delete();
    lvl_seen  = 1'b0;
    other_evt = 1'b0;
  endtask

  // Records press/release edge numbers on channel ch; never judges.
  task automatic observe(input int n, input int ch);
    for (int k = 0; k < n; k++) begin
      step();
      if (btn_press[ch])   p_edges.push_back(ec);
      if (btn_release[ch]) r_edges.push_back(ec);
      if (btn_level[ch])   lvl_seen = 1'b1;
      for (int j = 0; j < 4; j++)
        if (j != ch && (btn_press[j] || btn_release[j])) other_evt = 1'b1;
    end
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; btn_raw = 4'b0000;
    repeat (3) step();
    tests++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 000", {btn_level, btn_press, btn_release});
    end
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_clean_press();
    int exp_cnt;
`ifdef AUTOREPEAT_EN
    exp_cnt = 3;
`else
    exp_cnt = 1;
`endif
    clear_obs();
    btn_raw[0] = 1'b1;
    observe(17, 0);
    tests++;
    if (btn_level[0] !== 1'b0 || p_edges.size() != 0) begin
      fails++;
      $display("FAIL press_early: level %b presses %0d, expected 0 and 0", btn_level[0], p_edges.size());
    end
    observe(83, 0);
    tests++;
    if (first_of(p_edges) != 18) begin
      fails++;
      $display("FAIL press_edge: got %0d expected 18", first_of(p_edges));
    end
    tests++;
    if (p_edges.size() != exp_cnt) begin
      fails++;
      $display("FAIL press_count: got %0d expected %0d", p_edges.size(), exp_cnt);
    end
    tests++;
    if (btn_level !== 4'b0001 || other_evt) begin
      fails++;
      $display("FAIL held_level: got %b other_evt %0d expected 0001 and 0", btn_level, other_evt);
    end
    clear_obs();
    btn_raw[0] = 1'b0;
    observe(40, 0);
    tests++;
    if (first_of(r_edges) != 18 || r_edges.size() != 1) begin
      fails++;
      $display("FAIL release_edge: got edge %0d count %0d expected 18 and 1", first_of(r_edges), r_edges.size());
    end
    tests++;
    if (btn_level[0] !== 1'b0 || p_edges.size() != 0) begin
      fails++;
      $display("FAIL release_level: level %b presses %0d expected 0 and 0", btn_level[0], p_edges.size());
    end
  endtask

  task automatic test_bounce();
    clear_obs();
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) btn_raw[2] = ~btn_raw[2];
      step();
      if (btn_press[2])   p_edges.push_back(ec);
      if (btn_release[2]) r_edges.push_back(ec);
      if (btn_level[2])   lvl_seen = 1'b1;
    end
    btn_raw[2] = 1'b0;
    observe(40, 2);
    tests++;
    if (p_edges.size() != 0 || r_edges.size() != 0 || lvl_seen) begin
      fails++;
      $display("FAIL bounce: presses %0d releases %0d level_seen %0d expected 0 0 0",
               p_edges.size(), r_edges.size(), lvl_seen);
    end
  endtask

  task automatic test_simultaneous();
    bit early;
    early = 1'b0;
    ec = 0;
    btn_raw = 4'b1111;
    repeat (17) begin
      step();
      if (btn_press !== 4'b0000) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL simul_early: press seen before edge 18, expected none");
    end
    step();
    tests++;
    if (btn_press !== 4'b1111) begin
      fails++;
      $display("FAIL simul_press: got %b expected 1111", btn_press);
    end
    step();
    tests++;
    if (btn_press !== 4'b0000 || btn_level !== 4'b1111) begin
      fails++;
      $display("FAIL simul_after: press %b level %b expected 0000 1111", btn_press, btn_level);
    end
    btn_raw = 4'b0000;
    repeat (30) step();
    tests++;
    if (btn_level !== 4'b0000) begin
      fails++;
      $display("FAIL simul_release: level %b expected 0000", btn_level);
    end
  endtask

  task automatic test_reset_held();
    clear_obs();
    btn_raw[1] = 1'b1;
    observe(30, 1);
    tests++;
    if (btn_level[1] !== 1'b1 || p_edges.size() != 1) begin
      fails++;
      $display("FAIL rst_pre_held: level %b presses %0d expected 1 and 1", btn_level[1], p_edges.size());
    end
    rst = 1'b1;
    step();
    tests++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      fails++;
      $display("FAIL rst_mid_held: got %h expected 000", {btn_level, btn_press, btn_release});
    end
    rst = 1'b0;
    clear_obs();
    observe(30, 1);
    tests++;
    if (first_of(p_edges) != 18 || p_edges.size() != 1 || r_edges.size() != 0) begin
      fails++;
      $display("FAIL rst_repress: edge %0d presses %0d releases %0d expected 18 1 0",
               first_of(p_edges), p_edges.size(), r_edges.size());
    end
    btn_raw[1] = 1'b0;
    observe(40, 1);
  endtask

  task automatic test_autorepeat();
    int exp_cnt;
`ifdef AUTOREPEAT_EN
    exp_cnt = 9;
`else
    exp_cnt = 1;
`endif
    clear_obs();
    btn_raw[0] = 1'b1;
    observe(200, 0);
    tests++;
    if (p_edges.size() != exp_cnt || first_of(p_edges) != 18) begin
      fails++;
      $display("FAIL repeat_count: presses %0d first %0d expected %0d and 18",
               p_edges.size(), first_of(p_edges), exp_cnt);
    end
`ifdef AUTOREPEAT_EN
    tests++;
    if (p_edges.size() < 3 || p_edges[1] != 82 || p_edges[2] != 98) begin
      fails++;
      $display("FAIL repeat_edges: got %0d presses, need second at 82 and third at 98", p_edges.size());
    end
`endif
    btn_raw[0] = 1'b0;
    observe(40, 0);
  endtask

  task automatic test_ena();
    clear_obs();
    btn_raw[0] = 1'b1;
    observe(5, 0);
    ena = 1'b0;
    observe(20, 0);
    tests++;
    if (p_edges.size() != 0 || btn_level[0] !== 1'b0) begin
      fails++;
      $display("FAIL ena_low: presses %0d level %b expected 0 and 0", p_edges.size(), btn_level[0]);
    end
    ena = 1'b1;
    observe(20, 0);
    tests++;
    if (first_of(p_edges) != 38 || p_edges.size() != 1) begin
      fails++;
      $display("FAIL ena_resume: edge %0d presses %0d expected 38 and 1", first_of(p_edges), p_edges.size());
    end
    btn_raw[0] = 1'b0;
    observe(40, 0);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_held();
    test_autorepeat();
    test_ena();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
